sa_seq_ctrl: RTL

- Sequencer for an ROWS x COLS weight-stationary systolic array built from the team's PE cells: 9-bit signed weights, 32-bit signed partial sums flowing down, activations entering from the left.
- Buffers one weight tile, then bursts it contiguously down each column while the array is in store mode.
- Streams activation vectors into the left edge with per-row skew.
- Raises per-column result strobes aligned to the bottom-row outputs, then pulses done.

---
 rtl/sa_pkg.sv | 21 ++
 rtl/sa_skew_line.sv | 35 +++
 rtl/sa_seq_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared types for the systolic-array sequencer: PE word types, FSM states
// and the weight sign-extension helper.
package sa_pkg;

  typedef logic signed [8:0]  int9_t;
  typedef logic signed [31:0] int32_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_PUSH_W,
    ST_CALC,
    ST_DRAIN,
    ST_DONE
  } sa_state_t;

  function automatic int32_t sext_w(input int9_t w);
    return {{23{w[8]}}, w};
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Fixed-latency shift register carrying a valid bit alongside a data word.
// Output is the last flop, so total latency from input to output is DEPTH.
module sa_skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 9
) (
  input  logic             PE_clk,
  input  logic             PE_rst_n,
  input  logic             shift_vld,
  input  logic [WIDTH-1:0] shift_data,
  output logic             tap_vld,
  output logic [WIDTH-1:0] tap_data
);

  logic [DEPTH-1:0] vld_sr;
  logic [WIDTH-1:0] dat_sr [DEPTH];

  always_ff @(posedge PE_clk or negedge PE_rst_n) begin
    if (!PE_rst_n) begin
      vld_sr <= '0;
      for (int i = 0; i < DEPTH; i++) dat_sr[i] <= '0;
    end else begin
      vld_sr[0] <= shift_vld;
      dat_sr[0] <= shift_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        dat_sr[i] <= dat_sr[i-1];
      end
    end
  end

  assign tap_vld  = vld_sr[DEPTH-1];
  assign tap_data = dat_sr[DEPTH-1];

endmodule

// File: rtl/sa_seq_ctrl.sv
// Weight-stationary systolic-array sequencer: buffers a weight tile, bursts it
// into the array, streams skewed activations and strobes results. Option: SA_BIAS_EN.
//
// state    | meaning
// IDLE     | waiting for start, num_vec latched on start
// LOAD_W   | accepting ROWS weight rows into the tile buffer
// PUSH_W   | ROWS-cycle contiguous store burst, last buffered row first
// CALC     | accepting activation vectors until num_vec issued
// DRAIN    | letting skew and strobe lines empty
// DONE     | one-cycle done pulse
module sa_seq_ctrl
  import sa_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CNT_W = 16
) (
  input  logic                 PE_clk,
  input  logic                 PE_rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_vec,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [COLS*9-1:0]    w_data,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ROWS*9-1:0]    a_data,
`ifdef SA_BIAS_EN
  input  logic [COLS*32-1:0]   bias_data,
`endif
  output logic                 pe_mode,
  output logic [COLS-1:0]      pe_en_up,
  output logic [COLS*32-1:0]   pe_data_up,
  output logic [ROWS-1:0]      pe_en_left,
  output logic [ROWS*9-1:0]    pe_data_left,
  output logic [COLS-1:0]      res_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = $clog2(ROWS + COLS);
  localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(ROWS + COLS - 1);

  sa_state_t          state, state_nxt;
  logic [RW-1:0]      row_idx;
  logic [CNT_W-1:0]   vec_left;
  logic [DW-1:0]      drain_cnt;
  logic [COLS*9-1:0]  wbuf [ROWS];
  logic               a_fire;
  logic               mode_nxt;
  logic [COLS-1:0]    en_up_nxt;
  logic [COLS*32-1:0] data_up_nxt;
  logic [COLS*32-1:0] bias_word;
  logic [COLS-1:0]    strobe_vld, strobe_dat;

`ifdef SA_BIAS_EN
  logic [COLS*32-1:0] bias_lat;

  always_ff @(posedge PE_clk or negedge PE_rst_n) begin
    if (!PE_rst_n)                      bias_lat <= '0;
    else if (state == ST_IDLE && start) bias_lat <= bias_data;
  end
  assign bias_word = bias_lat;
`else
  assign bias_word = '0;
`endif

  always_ff @(posedge PE_clk or negedge PE_rst_n) begin
    if (!PE_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    w_ready     = 1'b0;
    a_ready     = 1'b0;
    mode_nxt    = 1'b0;
    en_up_nxt   = '0;
    data_up_nxt = '0;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_LOAD_W;
      ST_LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid && row_idx == LAST_ROW) state_nxt = ST_PUSH_W;
      end
      ST_PUSH_W: begin
        mode_nxt  = 1'b1;
        en_up_nxt = '1;
        for (int c = 0; c < COLS; c++)
          data_up_nxt[c*32 +: 32] = sext_w(int9_t'(wbuf[row_idx][c*9 +: 9]));
        if (row_idx == '0) state_nxt = (vec_left != '0) ? ST_CALC : ST_DONE;
      end
      ST_CALC: begin
        a_ready     = (vec_left != '0);
        data_up_nxt = bias_word;
        if (a_valid && vec_left == CNT_W'(1)) state_nxt = ST_DRAIN;
      end
      // Bias stays up through DRAIN so farther columns of the last vector still see it.
      ST_DRAIN: begin
        data_up_nxt = bias_word;
        if (drain_cnt == '0) state_nxt = ST_DONE;
      end
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign a_fire = a_valid && a_ready;
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);

  always_ff @(posedge PE_clk or negedge PE_rst_n) begin
    if (!PE_rst_n) begin
      row_idx   <= '0;
      vec_left  <= '0;
      drain_cnt <= '0;
      for (int r = 0; r < ROWS; r++) wbuf[r] <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          vec_left <= num_vec;
          row_idx  <= '0;
        end
        // row_idx parks on the last row so PUSH_W can count it back down to 0.
        ST_LOAD_W: if (w_valid) begin
          wbuf[row_idx] <= w_data;
          if (row_idx != LAST_ROW) row_idx <= row_idx + RW'(1);
        end
        ST_PUSH_W: if (row_idx != '0) row_idx <= row_idx - RW'(1);
        ST_CALC: begin
          if (a_fire) vec_left <= vec_left - CNT_W'(1);
          drain_cnt <= DRAIN_LAST;
        end
        ST_DRAIN: if (drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge PE_clk or negedge PE_rst_n) begin
    if (!PE_rst_n) begin
      pe_mode    <= 1'b0;
      pe_en_up   <= '0;
      pe_data_up <= '0;
    end else begin
      pe_mode    <= mode_nxt;
      pe_en_up   <= en_up_nxt;
      pe_data_up <= data_up_nxt;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    sa_skew_line #(.DEPTH(r + 1), .WIDTH(9)) u_skew (
      .PE_clk     (PE_clk),
      .PE_rst_n   (PE_rst_n),
      .shift_vld  (a_fire),
      .shift_data (a_fire ? a_data[r*9 +: 9] : 9'd0),
      .tap_vld    (pe_en_left[r]),
      .tap_data   (pe_data_left[r*9 +: 9])
    );
  end

  // Column c result leaves the bottom row ROWS cycles after row 0 entry, plus c hops.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    sa_skew_line #(.DEPTH(ROWS + 1 + c), .WIDTH(1)) u_strobe (
      .PE_clk     (PE_clk),
      .PE_rst_n   (PE_rst_n),
      .shift_vld  (a_fire),
      .shift_data (a_fire),
      .tap_vld    (strobe_vld[c]),
      .tap_data   (strobe_dat[c])
    );
    assign res_valid[c] = strobe_vld[c] & strobe_dat[c];
  end

endmodule
